axi_generator: RTL and testbench
================================

// Module: axi_generator
// PURPOSE
//  AXI4-Full write master generating a test-pattern stream as back-to-back INCR bursts.
//  Source-side counterpart of the AXI write-slave checker: data it emits must pass that
//  checker (counter / zeros pattern) with zero data errors.
//  Sits in axis_infrastructure test harnesses; driven by static config ports, reports
//  burst and error counts.
// PARAMETERS
//  N_BYTES      4         data bus width in bytes (power of 2)
//  ADDR_WIDTH   20        M_AXI_AWADDR width
//  ID_WIDTH     1         AWID/BID width
//  MODE         "SINGLE"  "SINGLE": incrementing beat counter; "ZEROS": all-zero data
//  AWID_VALUE   0         constant driven on M_AXI_AWID
// PORTS
//  aclk            in   1             clock
//  aresetn         in   1             sync active-low reset
//  ENABLE          in   1             run generator while high
//  BURST_LEN       in   8             AWLEN value (beats-1)
//  PAUSE           in   32            idle cycles between B handshake and next AW
//  BASE_ADDR       in   ADDR_WIDTH    first burst address
//  ADDR_RANGE      in   ADDR_WIDTH    window size in bytes; address wraps to BASE_ADDR
//  BUSY            out  1             FSM not in IDLE
//  BURST_CNT       out  32            completed bursts (B handshakes)
//  BRESP_ERR_CNT   out  32            B handshakes with BRESP != OKAY
//  M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS/AWVALID  out
//  M_AXI_AWREADY   in   1
//  M_AXI_WDATA out N_BYTES*8; M_AXI_WSTRB out N_BYTES; M_AXI_WLAST/WVALID out 1
//  M_AXI_WREADY    in   1
//  M_AXI_BID in ID_WIDTH; M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1
// BEHAVIOUR
//  Reset (aresetn=0, sampled at aclk): AWVALID/WVALID/WLAST/BREADY=0, BUSY=0, counters=0,
//   data counter=0, address=BASE_ADDR, FSM=IDLE. Reset mid-burst aborts immediately.
//  Constant fields: AWSIZE=clog2(N_BYTES), AWBURST=2'b01, AWCACHE=4'b0011, AWLOCK/AWPROT/
//   AWQOS=0, WSTRB=all ones, AWID=AWID_VALUE.
//  FSM IDLE->AW->W->B->GAP->(AW|IDLE):
//   IDLE: ENABLE=1 -> AW next cycle; BURST_LEN/PAUSE latched on this transition.
//   AW: AWVALID=1, AWADDR/AWLEN stable until AWVALID&AWREADY -> W.
//   W: WVALID=1 (no W before AW handshake); beat advances only on WVALID&WREADY;
//    WLAST=1 on beat index == latched BURST_LEN; last handshake -> B.
//   B: BREADY=1; on BVALID: BURST_CNT++, BRESP!=0 -> BRESP_ERR_CNT++; -> GAP.
//   GAP: count PAUSE cycles (PAUSE=0 -> zero extra cycles, AW follows directly);
//    then ENABLE ? AW : IDLE. ENABLE drop never truncates a burst in flight.
//  Data: SINGLE -> WDATA = beat counter, +1 per W handshake, mod 2^(N_BYTES*8),
//   continuous across bursts and across ENABLE cycles; ZEROS -> 0.
//  Address: after each AW handshake addr += (AWLEN+1)*N_BYTES; if new addr + next burst
//   bytes > BASE_ADDR+ADDR_RANGE -> addr=BASE_ADDR. Config must keep bursts within 4KB.
//  Counters wrap mod 2^32. Outputs change only in registered logic (no comb AXI paths).
// STRUCTURE
//  axi_gen_pkg: fsm_t enum {IDLE,AW,W,B,GAP}; AXI_BURST_INCR, AXI_RESP_OKAY, AXI_CACHE.
//  One sub-module natural: axi_gen_pattern (data counter / zeros, advance on handshake).
// TESTING
//  1 BURST_LEN=3,PAUSE=0,slave always ready: 4 beats 0..3, WLAST on beat 3, next burst
//    data 4..7, AWADDR 0x0,0x10,0x20.
//  2 Random WREADY/AWREADY backpressure, 100 bursts len 15: data contiguous 0..1599,
//    BURST_CNT=100, all AW/W signals stable while stalled.
//  3 BASE_ADDR=0x100,ADDR_RANGE=0x40,BURST_LEN=3: addresses 0x100,0x110,0x120,0x130,0x100.
//  4 ENABLE dropped at beat 2 of len-7 burst: burst completes 8 beats, B taken, BUSY=0.
//  5 Slave returns BRESP=2'b10 on every 3rd burst, 9 bursts: BRESP_ERR_CNT=3.
//  6 aresetn low mid-W: next cycle WVALID=0, counters 0; restart data begins at 0.

Source files
------------

// File: rtl/axi_gen_pkg.sv
// Shared types and AXI constants for the write-pattern generator.
package axi_gen_pkg;

   typedef enum logic [2:0] {
      IDLE,
      AW,
      W,
      B,
      GAP
   } fsm_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [3:0] AXI_CACHE      = 4'b0011;

endpackage

// File: rtl/axi_gen_if.sv
// AXI4 write-channel bundle (AW, W, B) between generator and slave.
interface axi_gen_if #(
   parameter int N_BYTES    = 4,
   parameter int ADDR_WIDTH = 20,
   parameter int ID_WIDTH   = 1
);

   logic [ID_WIDTH-1:0]    AWID;
   logic [ADDR_WIDTH-1:0]  AWADDR;
   logic [7:0]             AWLEN;
   logic [2:0]             AWSIZE;
   logic [1:0]             AWBURST;
   logic                   AWLOCK;
   logic [3:0]             AWCACHE;
   logic [2:0]             AWPROT;
   logic [3:0]             AWQOS;
   logic                   AWVALID;
   logic                   AWREADY;
   logic [N_BYTES*8-1:0]   WDATA;
   logic [N_BYTES-1:0]     WSTRB;
   logic                   WLAST;
   logic                   WVALID;
   logic                   WREADY;
   logic [ID_WIDTH-1:0]    BID;
   logic [1:0]             BRESP;
   logic                   BVALID;
   logic                   BREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
      output AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
      output WDATA, WSTRB, WLAST, WVALID, BREADY,
      input  AWREADY, WREADY, BID, BRESP, BVALID
   );

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
      input  AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
      input  WDATA, WSTRB, WLAST, WVALID, BREADY,
      output AWREADY, WREADY, BID, BRESP, BVALID
   );

endinterface

// File: rtl/axi_gen_pattern.sv
// Write-data source: free-running beat counter or constant zeros.
module axi_gen_pattern #(
   parameter int    N_BYTES = 4,
   parameter string MODE    = "SINGLE"
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 advance,
   output logic [N_BYTES*8-1:0] data
);

   logic [N_BYTES*8-1:0] cnt;

   // Never cleared between bursts: the stream stays contiguous.
   always_ff @(posedge aclk) begin
      if (!aresetn)
         cnt <= '0;
      else if (advance)
         cnt <= cnt + 1'b1;
   end

   assign data = (MODE == "ZEROS") ? '0 : cnt;

endmodule

// File: rtl/axi_generator.sv
// AXI4 write master emitting back-to-back INCR bursts of a test pattern.
module axi_generator
   import axi_gen_pkg::*;
#(
   parameter int                  N_BYTES    = 4,
   parameter int                  ADDR_WIDTH = 20,
   parameter int                  ID_WIDTH   = 1,
   parameter string               MODE       = "SINGLE",
   parameter logic [ID_WIDTH-1:0] AWID_VALUE = '0
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  ENABLE,
   input  logic [7:0]            BURST_LEN,
   input  logic [31:0]           PAUSE,
   input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
   input  logic [ADDR_WIDTH-1:0] ADDR_RANGE,
   output logic                  BUSY,
   output logic [31:0]           BURST_CNT,
   output logic [31:0]           BRESP_ERR_CNT,
   axi_gen_if.master             m_axi
);

   localparam int AXW = ADDR_WIDTH + 2;

   fsm_t                  state;
   logic [7:0]            len_q;
   logic [7:0]            beat;
   logic [31:0]           pause_q;
   logic [31:0]           gap;
   logic [ADDR_WIDTH-1:0] addr;
   logic [AXW-1:0]        bytes;
   logic [AXW-1:0]        nxt;
   logic [AXW-1:0]        lim;
   logic                  wrap;
   logic                  w_hs;
   logic                  unused_bid;

   assign unused_bid = ^m_axi.BID;

   assign bytes = AXW'((32'(len_q) + 32'd1) * 32'(N_BYTES));
   assign nxt   = AXW'(addr) + bytes;
   assign lim   = AXW'(BASE_ADDR) + AXW'(ADDR_RANGE);
   // Wrap when the following burst would spill past the window.
   assign wrap  = (nxt + bytes) > lim;
   assign w_hs  = (state == W) && m_axi.WREADY;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state         <= IDLE;
         len_q         <= '0;
         beat          <= '0;
         pause_q       <= '0;
         gap           <= '0;
         addr          <= BASE_ADDR;
         BURST_CNT     <= '0;
         BRESP_ERR_CNT <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ENABLE) begin
                  len_q   <= BURST_LEN;
                  pause_q <= PAUSE;
                  state   <= AW;
               end
            end
            AW: begin
               if (m_axi.AWREADY) begin
                  state <= W;
                  beat  <= '0;
                  addr  <= wrap ? BASE_ADDR : ADDR_WIDTH'(nxt);
               end
            end
            W: begin
               if (m_axi.WREADY) begin
                  if (beat == len_q)
                     state <= B;
                  else
                     beat <= beat + 8'd1;
               end
            end
            B: begin
               if (m_axi.BVALID) begin
                  BURST_CNT <= BURST_CNT + 32'd1;
                  if (m_axi.BRESP != AXI_RESP_OKAY)
                     BRESP_ERR_CNT <= BRESP_ERR_CNT + 32'd1;
                  if (pause_q == 32'd0) begin
                     state <= ENABLE ? AW : IDLE;
                  end else begin
                     gap   <= pause_q - 32'd1;
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               if (gap == 32'd0)
                  state <= ENABLE ? AW : IDLE;
               else
                  gap <= gap - 32'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   axi_gen_pattern #(
      .N_BYTES (N_BYTES),
      .MODE    (MODE)
   ) u_pattern (
      .aclk    (aclk),
      .aresetn (aresetn),
      .advance (w_hs),
      .data    (m_axi.WDATA)
   );

   assign BUSY          = (state != IDLE);
   assign m_axi.AWID    = AWID_VALUE;
   assign m_axi.AWADDR  = addr;
   assign m_axi.AWLEN   = len_q;
   assign m_axi.AWSIZE  = 3'($clog2(N_BYTES));
   assign m_axi.AWBURST = AXI_BURST_INCR;
   assign m_axi.AWLOCK  = 1'b0;
   assign m_axi.AWCACHE = AXI_CACHE;
   assign m_axi.AWPROT  = 3'b000;
   assign m_axi.AWQOS   = 4'b0000;
   assign m_axi.AWVALID = (state == AW);
   assign m_axi.WSTRB   = '1;
   assign m_axi.WVALID  = (state == W);
   assign m_axi.WLAST   = (state == W) && (beat == len_q);
   assign m_axi.BREADY  = (state == B);

endmodule

// File: tb/tb_axi_generator.sv
// Directed bench: scenario table plus hand sequences for enable drop and reset.
module tb_axi_generator;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        ENABLE;
   logic [7:0]  BURST_LEN;
   logic [31:0] PAUSE;
   logic [19:0] BASE_ADDR;
   logic [19:0] ADDR_RANGE;
   logic        BUSY;
   logic [31:0] BURST_CNT;
   logic [31:0] BRESP_ERR_CNT;

   axi_gen_if #(
      .N_BYTES    (4),
      .ADDR_WIDTH (20),
      .ID_WIDTH   (1)
   ) m_axi ();

   axi_generator #(
      .N_BYTES    (4),
      .ADDR_WIDTH (20),
      .ID_WIDTH   (1),
      .MODE       ("SINGLE"),
      .AWID_VALUE (1'b0)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .ENABLE        (ENABLE),
      .BURST_LEN     (BURST_LEN),
      .PAUSE         (PAUSE),
      .BASE_ADDR     (BASE_ADDR),
      .ADDR_RANGE    (ADDR_RANGE),
      .BUSY          (BUSY),
      .BURST_CNT     (BURST_CNT),
      .BRESP_ERR_CNT (BRESP_ERR_CNT),
      .m_axi         (m_axi)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      int len;
      int pause;
      int base;
      int range;
      int nb;
      int bp;
      int err_every;
      int exp_last_addr;
      int exp_beats;
      int exp_err;
   } scn_t;

   scn_t tbl[4];

   int          n_chk;
   int          n_fail;
   int          cyc;
   int          aw_cnt;
   int          w_cnt;
   int          b_cnt;
   int          beat;
   int          last_b_cyc;
   int          stop_after;
   int          err_every;
   int          bp;
   int          exp_addr;
   int          last_addr;
   int          cur_len;
   int          cur_pause;
   int          cur_base;
   int          cur_range;
   bit          in_w;
   bit          b_due;
   bit          aw_stall;
   bit          w_stall;
   logic [31:0] exp_data;
   logic [19:0] st_addr;
   logic [31:0] st_data;
   logic        st_last;

   task automatic chk_eq(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic reset_model();
      aw_cnt     = 0;
      w_cnt      = 0;
      b_cnt      = 0;
      beat       = 0;
      last_b_cyc = -1;
      in_w       = 0;
      b_due      = 0;
      aw_stall   = 0;
      w_stall    = 0;
      exp_data   = '0;
      exp_addr   = cur_base;
   endtask

   task automatic set_cfg(input int len, input int pause,
                          input int base, input int range);
      cur_len    = len;
      cur_pause  = pause;
      cur_base   = base;
      cur_range  = range;
      BURST_LEN  = 8'(len);
      PAUSE      = 32'(pause);
      BASE_ADDR  = 20'(base);
      ADDR_RANGE = 20'(range);
   endtask

   task automatic do_reset();
      aresetn       = 1'b0;
      ENABLE        = 1'b0;
      m_axi.AWREADY = 1'b0;
      m_axi.WREADY  = 1'b0;
      m_axi.BVALID  = 1'b0;
      m_axi.BRESP   = 2'b00;
      repeat (2) @(negedge aclk);
      chk_eq("rst_awvalid", m_axi.AWVALID, 0);
      chk_eq("rst_wvalid", m_axi.WVALID, 0);
      chk_eq("rst_wlast", m_axi.WLAST, 0);
      chk_eq("rst_bready", m_axi.BREADY, 0);
      chk_eq("rst_busy", BUSY, 0);
      chk_eq("rst_burst_cnt", BURST_CNT, 0);
      chk_eq("rst_err_cnt", BRESP_ERR_CNT, 0);
      chk_eq("rst_awaddr", m_axi.AWADDR, cur_base);
      aresetn = 1'b1;
      reset_model();
   endtask

   // One slave cycle: check held values, pick readies, score handshakes.
   task automatic step();
      bit aw_new;
      @(negedge aclk);
      cyc++;
      if (aw_stall) begin
         chk_eq("aw_stable_valid", m_axi.AWVALID, 1);
         chk_eq("aw_stable_addr", m_axi.AWADDR, st_addr);
      end
      if (w_stall) begin
         chk_eq("w_stable_valid", m_axi.WVALID, 1);
         chk_eq("w_stable_data", m_axi.WDATA, st_data);
         chk_eq("w_stable_last", m_axi.WLAST, st_last);
      end
      aw_new   = m_axi.AWVALID && !aw_stall;
      aw_stall = 0;
      w_stall  = 0;
      m_axi.AWREADY = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi.WREADY  = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi.BVALID  = b_due;
      m_axi.BRESP   = (b_due && err_every > 0 &&
                       ((b_cnt + 1) % err_every) == 0) ? 2'b10 : 2'b00;
      if (b_due && m_axi.BREADY) begin
         b_cnt++;
         b_due      = 0;
         last_b_cyc = cyc;
         if (stop_after > 0 && b_cnt == stop_after)
            ENABLE = 1'b0;
      end
      if (aw_new && last_b_cyc >= 0)
         chk_eq("aw_gap", cyc - last_b_cyc, cur_pause + 1);
      if (m_axi.AWVALID) begin
         if (m_axi.AWREADY) begin
            chk_eq("awaddr", m_axi.AWADDR, exp_addr);
            chk_eq("awlen", m_axi.AWLEN, cur_len);
            last_addr = int'(m_axi.AWADDR);
            aw_cnt++;
            in_w = 1;
            beat = 0;
            exp_addr = exp_addr + (cur_len + 1) * 4;
            if (exp_addr + (cur_len + 1) * 4 > cur_base + cur_range)
               exp_addr = cur_base;
         end else begin
            aw_stall = 1;
            st_addr  = m_axi.AWADDR;
         end
      end
      if (m_axi.WVALID) begin
         chk_eq("w_after_aw", in_w, 1);
         if (m_axi.WREADY) begin
            chk_eq("wdata", m_axi.WDATA, exp_data);
            chk_eq("wlast", m_axi.WLAST, beat == cur_len);
            exp_data++;
            w_cnt++;
            if (beat == cur_len) begin
               in_w  = 0;
               b_due = 1;
            end else begin
               beat++;
            end
         end else begin
            w_stall = 1;
            st_data = m_axi.WDATA;
            st_last = m_axi.WLAST;
         end
      end
   endtask

   task automatic run_until_b(input int n, input int limit, input string name);
      int k = 0;
      while (b_cnt < n && k < limit) begin
         step();
         k++;
      end
      chk_eq(name, b_cnt, n);
   endtask

   task automatic wait_idle(input int limit, input string name);
      int k = 0;
      while (BUSY && k < limit) begin
         step();
         k++;
      end
      chk_eq(name, BUSY, 0);
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      cyc        = 0;
      stop_after = 0;
      err_every  = 0;
      bp         = 0;
      last_addr  = 0;
      m_axi.BID  = 1'b0;
      set_cfg(3, 0, 0, 'h1000);
      reset_model();

      //          len pause base    range   nb  bp err last    beats err
      tbl[0] = '{3,  0,    0,      'h1000, 3,  0, 0,  'h20,   12,   0};
      tbl[1] = '{15, 0,    0,      'h1000, 100,1, 0,  'h8C0,  1600, 0};
      tbl[2] = '{3,  2,    'h100,  'h40,   5,  0, 0,  'h100,  20,   0};
      tbl[3] = '{1,  1,    0,      'h1000, 9,  0, 3,  'h40,   18,   3};

      do_reset();
      chk_eq("awsize", m_axi.AWSIZE, 2);
      chk_eq("awburst", m_axi.AWBURST, 1);
      chk_eq("awcache", m_axi.AWCACHE, 3);
      chk_eq("awlock_prot_qos",
             {m_axi.AWLOCK, m_axi.AWPROT, m_axi.AWQOS}, 0);
      chk_eq("wstrb", m_axi.WSTRB, 4'hF);
      chk_eq("awid", m_axi.AWID, 0);

      for (int i = 0; i < 4; i++) begin
         set_cfg(tbl[i].len, tbl[i].pause, tbl[i].base, tbl[i].range);
         bp        = tbl[i].bp;
         err_every = tbl[i].err_every;
         do_reset();
         stop_after = tbl[i].nb;
         ENABLE     = 1'b1;
         run_until_b(tbl[i].nb, 20000, "scn_bursts");
         wait_idle(200, "scn_idle");
         chk_eq("scn_burst_cnt", BURST_CNT, tbl[i].nb);
         chk_eq("scn_err_cnt", BRESP_ERR_CNT, tbl[i].exp_err);
         chk_eq("scn_last_addr", last_addr, tbl[i].exp_last_addr);
         chk_eq("scn_beats", w_cnt, tbl[i].exp_beats);
         chk_eq("scn_aw_cnt", aw_cnt, tbl[i].nb);
      end

      // ENABLE dropped mid-burst, then resumed with contiguous data.
      bp        = 0;
      err_every = 0;
      set_cfg(7, 0, 0, 'h1000);
      do_reset();
      stop_after = 0;
      ENABLE     = 1'b1;
      for (int k = 0; k < 50 && w_cnt < 2; k++)
         step();
      ENABLE = 1'b0;
      wait_idle(200, "drop_idle");
      chk_eq("drop_beats", w_cnt, 8);
      chk_eq("drop_burst_cnt", BURST_CNT, 1);
      chk_eq("drop_aw_cnt", aw_cnt, 1);
      last_b_cyc = -1;
      stop_after = 2;
      ENABLE     = 1'b1;
      run_until_b(2, 200, "resume_bursts");
      wait_idle(200, "resume_idle");
      chk_eq("resume_beats", w_cnt, 16);
      chk_eq("resume_data_next", exp_data, 16);
      chk_eq("resume_burst_cnt", BURST_CNT, 2);

      // Reset asserted during the W phase of the second burst.
      set_cfg(3, 0, 0, 'h1000);
      do_reset();
      stop_after = 0;
      ENABLE     = 1'b1;
      for (int k = 0; k < 100 && w_cnt < 6; k++)
         step();
      chk_eq("mid_wvalid_before", m_axi.WVALID, 1);
      aresetn       = 1'b0;
      ENABLE        = 1'b0;
      m_axi.AWREADY = 1'b0;
      m_axi.WREADY  = 1'b0;
      m_axi.BVALID  = 1'b0;
      @(negedge aclk);
      chk_eq("mid_rst_wvalid", m_axi.WVALID, 0);
      chk_eq("mid_rst_burst_cnt", BURST_CNT, 0);
      chk_eq("mid_rst_busy", BUSY, 0);
      aresetn = 1'b1;
      reset_model();
      stop_after = 1;
      ENABLE     = 1'b1;
      run_until_b(1, 200, "post_rst_bursts");
      wait_idle(200, "post_rst_idle");
      chk_eq("post_rst_beats", w_cnt, 4);
      chk_eq("post_rst_burst_cnt", BURST_CNT, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
